// File: rtl/mem_responder.sv
// mem_responder: word-organised memory that answers byte/half/word load-store requests
// after a fixed LATENCY, rejecting misaligned, illegal-size and out-of-range accesses.
module mem_responder #(
    parameter int LATENCY     = 2,
    parameter int DEPTH_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        ack,
    output logic [31:0] rdata,
    output logic        err
);
    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} stateE;

    stateE       state;
    stateE       nextState;
    logic [3:0]  waitCnt;
    logic        errQ;
    logic        capture;
    logic        enterResp;

    logic        weQ;
    logic        unsQ;
    logic [1:0]  sizeQ;
    logic [31:0] addrQ;
    logic [31:0] wdataQ;

    logic        curWe;
    logic        curUns;
    logic [1:0]  curSize;
    logic [31:0] curAddr;
    logic [31:0] curWdata;

    logic             reqErr;
    logic [IDX_W-1:0] wordIdx;
    logic [31:0]      curWord;
    logic [7:0]       laneByte;
    logic [15:0]      laneHalf;
    logic [31:0]      loadValue;
    logic [31:0]      storeWord;

    logic [31:0] mem [DEPTH_WORDS];

    // NOTE: every signal driven here gets a default first, so no path can leave one
    // unassigned and infer a latch.
    always_comb begin
        nextState = state;
        capture   = 1'b0;
        enterResp = 1'b0;
        busy      = (state != IDLE);
        ack       = (state == RESP);
        err       = (state == RESP) && errQ;
        case (state)
            IDLE: begin
                if (req) begin
                    capture = 1'b1;
                    if (LATENCY == 0) begin
                        nextState = RESP;
                        enterResp = 1'b1;
                    end else begin
                        nextState = WAIT;
                    end
                end
            end
            WAIT: begin
                if (waitCnt == 4'd1) begin
                    nextState = RESP;
                    enterResp = 1'b1;
                end
            end
            RESP:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // With LATENCY=0 the access completes on the capture edge, so IDLE works on live inputs.
    always_comb begin
        if (state == IDLE) begin
            curWe    = we;
            curUns   = uns;
            curSize  = size;
            curAddr  = addr;
            curWdata = wdata;
        end else begin
            curWe    = weQ;
            curUns   = unsQ;
            curSize  = sizeQ;
            curAddr  = addrQ;
            curWdata = wdataQ;
        end
    end

    always_comb begin
        reqErr = ({2'b00, curAddr[31:2]} >= 32'(DEPTH_WORDS));
        case (curSize)
            2'b01:   if (curAddr[0]) reqErr = 1'b1;
            2'b10:   if (curAddr[1:0] != 2'b00) reqErr = 1'b1;
            2'b11:   reqErr = 1'b1;
            default: ;
        endcase

        wordIdx  = curAddr[IDX_W+1:2];
        curWord  = mem[wordIdx];
        laneByte = curWord[{curAddr[1:0], 3'b000} +: 8];
        laneHalf = curWord[{curAddr[1], 4'b0000} +: 16];

        case (curSize)
            2'b00:   loadValue = {{24{laneByte[7] & ~curUns}}, laneByte};
            2'b01:   loadValue = {{16{laneHalf[15] & ~curUns}}, laneHalf};
            default: loadValue = curWord;
        endcase

        storeWord = curWord;
        case (curSize)
            2'b00:   storeWord[{curAddr[1:0], 3'b000} +: 8] = curWdata[7:0];
            2'b01:   storeWord[{curAddr[1], 4'b0000} +: 16] = curWdata[15:0];
            default: storeWord = curWdata;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            waitCnt <= '0;
            errQ    <= 1'b0;
            rdata   <= '0;
        end else begin
            state <= nextState;
            if (capture) begin
                waitCnt <= 4'(LATENCY);
            end else if (state == WAIT) begin
                waitCnt <= waitCnt - 4'd1;
            end
            if (enterResp) begin
                errQ <= reqErr;
                if (reqErr) begin
                    rdata <= '0;
                end else if (!curWe) begin
                    rdata <= loadValue;
                end
            end
        end
    end

    // Request fields are only consumed after a capture, so they need no reset.
    always_ff @(posedge clk) begin
        if (rst && capture) begin
            weQ    <= we;
            unsQ   <= uns;
            sizeQ  <= size;
            addrQ  <= addr;
            wdataQ <= wdata;
        end
    end

    // NOTE: the array is deliberately not reset; contents survive rst and change only on
    // an accepted, error-free store.
    always_ff @(posedge clk) begin
        if (rst && enterResp && curWe && !reqErr) begin
            mem[wordIdx] <= storeWord;
        end
    end
endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: three instances (LATENCY 2, 0, 3) checked against
// an arithmetic memory model with randomized and directed load/store traffic.
module tb_mem_responder;
    localparam int DEPTH = 64;

    logic        clk;
    logic        rst;
    logic        we;
    logic        uns;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  reqV;
    logic [2:0]  busyV;
    logic [2:0]  ackV;
    logic [2:0]  errV;
    logic [31:0] rdata0;
    logic [31:0] rdata1;
    logic [31:0] rdata2;

    logic [31:0] refMem [3][DEPTH];
    logic [31:0] refRdata [3];
    int testsRun;
    int testsFailed;

    mem_responder #(.LATENCY(2), .DEPTH_WORDS(DEPTH)) dutL2 (
        .clk(clk), .rst(rst), .req(reqV[0]), .we(we), .size(size), .uns(uns),
        .addr(addr), .wdata(wdata), .busy(busyV[0]), .ack(ackV[0]), .rdata(rdata0), .err(errV[0])
    );
    mem_responder #(.LATENCY(0), .DEPTH_WORDS(DEPTH)) dutL0 (
        .clk(clk), .rst(rst), .req(reqV[1]), .we(we), .size(size), .uns(uns),
        .addr(addr), .wdata(wdata), .busy(busyV[1]), .ack(ackV[1]), .rdata(rdata1), .err(errV[1])
    );
    mem_responder #(.LATENCY(3), .DEPTH_WORDS(DEPTH)) dutL3 (
        .clk(clk), .rst(rst), .req(reqV[2]), .we(we), .size(size), .uns(uns),
        .addr(addr), .wdata(wdata), .busy(busyV[2]), .ack(ackV[2]), .rdata(rdata2), .err(errV[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int latOf(input int s);
        case (s)
            0:       return 2;
            1:       return 0;
            default: return 3;
        endcase
    endfunction

    function automatic logic [31:0] rdataOf(input int s);
        case (s)
            0:       return rdata0;
            1:       return rdata1;
            default: return rdata2;
        endcase
    endfunction

    function automatic bit refIsErr(input logic [1:0] sz, input logic [31:0] a);
        return (sz == 2'b11) || (sz == 2'b01 && (a % 2) != 0) ||
               (sz == 2'b10 && (a % 4) != 0) || ((a / 4) >= 32'(DEPTH));
    endfunction

    function automatic logic [31:0] refLoad(input logic [31:0] word, input logic [1:0] sz,
                                            input logic u, input logic [31:0] a);
        int sh;
        logic [31:0] v;
        if (sz == 2'b10) return word;
        if (sz == 2'b00) begin
            sh = 8 * int'(a % 4);
            v = (word >> sh) & 32'hFF;
            if (!u && v >= 32'h80) v = v + 32'hFFFF_FF00;
        end else begin
            sh = 16 * int'((a % 4) / 2);
            v = (word >> sh) & 32'hFFFF;
            if (!u && v >= 32'h8000) v = v + 32'hFFFF_0000;
        end
        return v;
    endfunction

    function automatic logic [31:0] refStore(input logic [31:0] old, input logic [1:0] sz,
                                             input logic [31:0] a, input logic [31:0] wd);
        int sh;
        logic [31:0] mask;
        if (sz == 2'b00) begin
            sh = 8 * int'(a % 4);
            mask = 32'hFF << sh;
        end else if (sz == 2'b01) begin
            sh = 16 * int'((a % 4) / 2);
            mask = 32'hFFFF << sh;
        end else begin
            sh = 0;
            mask = 32'hFFFF_FFFF;
        end
        return (old & ~mask) | ((wd << sh) & mask);
    endfunction

    // One complete request on instance s: checks timing, err, rdata and post-ack idle.
    task automatic access(input int s, input logic w, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] gotData, output logic gotErr);
        int ackAt;
        int busyCnt;
        bit strayErr;
        logic expErr;
        logic [31:0] expData;
        expErr = refIsErr(sz, a);
        if (expErr) expData = 32'h0;
        else if (w) expData = refRdata[s];
        else expData = refLoad(refMem[s][a / 4], sz, u, a);

        @(negedge clk);
        we = w; size = sz; uns = u; addr = a; wdata = wd; reqV[s] = 1'b1;
        @(posedge clk);
        #1 reqV[s] = 1'b0;
        ackAt = 0; busyCnt = 0; strayErr = 0; gotData = 32'h0; gotErr = 1'b0;
        for (int k = 1; k <= 40 && ackAt == 0; k++) begin
            @(negedge clk);
            if (busyV[s]) busyCnt++;
            if (!ackV[s] && errV[s]) strayErr = 1;
            if (ackV[s]) begin
                ackAt = k;
                gotData = rdataOf(s);
                gotErr = errV[s];
            end
        end
        testsRun++;
        if (ackAt != latOf(s) + 1) begin
            testsFailed++;
            $display("FAIL ack_cycle inst%0d addr %h: ack at cycle %0d, expected %0d", s, a, ackAt, latOf(s) + 1);
        end
        testsRun++;
        if (busyCnt != latOf(s) + 1) begin
            testsFailed++;
            $display("FAIL busy_cycles inst%0d addr %h: %0d, expected %0d", s, a, busyCnt, latOf(s) + 1);
        end
        testsRun++;
        if (gotErr !== expErr || strayErr) begin
            testsFailed++;
            $display("FAIL err inst%0d addr %h size %0d: err %b stray %0d, expected %b", s, a, sz, gotErr, strayErr, expErr);
        end
        testsRun++;
        if (gotData !== expData) begin
            testsFailed++;
            $display("FAIL rdata inst%0d we %b size %0d uns %b addr %h: got %h, expected %h", s, w, sz, u, a, gotData, expData);
        end
        @(negedge clk);
        testsRun++;
        if (busyV[s] !== 1'b0 || ackV[s] !== 1'b0 || errV[s] !== 1'b0) begin
            testsFailed++;
            $display("FAIL idle_after_ack inst%0d: busy %b ack %b err %b, expected 0 0 0", s, busyV[s], ackV[s], errV[s]);
        end
        if (!expErr && w) refMem[s][a / 4] = refStore(refMem[s][a / 4], sz, a, wd);
        refRdata[s] = expData;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0; reqV = 3'b111; we = 1'b1; size = 2'b10; uns = 1'b0; addr = 32'h0; wdata = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            testsRun++;
            if (busyV[s] !== 1'b0 || ackV[s] !== 1'b0 || errV[s] !== 1'b0) begin
                testsFailed++;
                $display("FAIL reset_flags inst%0d: busy %b ack %b err %b, expected 0 0 0", s, busyV[s], ackV[s], errV[s]);
            end
            testsRun++;
            if (rdataOf(s) !== 32'h0) begin
                testsFailed++;
                $display("FAIL reset_rdata inst%0d: got %h, expected 00000000", s, rdataOf(s));
            end
            refRdata[s] = 32'h0;
        end
        reqV = 3'b000; rst = 1'b1;
        @(negedge clk);
        testsRun++;
        if (busyV !== 3'b000 || ackV !== 3'b000) begin
            testsFailed++;
            $display("FAIL reset_req_discarded: busy %b ack %b, expected 000 000", busyV, ackV);
        end
    endtask

    task automatic test_init();
        logic [31:0] d;
        logic e;
        for (int i = 0; i < DEPTH; i++) access(0, 1'b1, 2'b10, 1'b0, 32'(i * 4), $urandom, d, e);
    endtask

    task automatic test_basic();
        logic [31:0] d;
        logic e;
        access(0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, d, e);
        access(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, d, e);
        testsRun++;
        if (d !== 32'hDEAD_BEEF || e !== 1'b0) begin
            testsFailed++;
            $display("FAIL basic_lw: got %h err %b, expected deadbeef err 0", d, e);
        end
    endtask

    task automatic test_sign_extend();
        logic [31:0] d;
        logic e;
        logic [1:0]  szT [4];
        logic        unsT [4];
        logic [31:0] adrT [4];
        logic [31:0] expT [4];
        szT  = '{2'b00, 2'b00, 2'b01, 2'b01};
        unsT = '{1'b0, 1'b1, 1'b0, 1'b1};
        adrT = '{32'h20, 32'h20, 32'h20, 32'h22};
        expT = '{32'hFFFF_FFF0, 32'h0000_00F0, 32'hFFFF_80F0, 32'h0000_0000};
        access(0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h0000_80F0, d, e);
        for (int i = 0; i < 4; i++) begin
            access(0, 1'b0, szT[i], unsT[i], adrT[i], 32'h0, d, e);
            testsRun++;
            if (d !== expT[i]) begin
                testsFailed++;
                $display("FAIL sign_extend case %0d: got %h, expected %h", i, d, expT[i]);
            end
        end
    endtask

    task automatic test_byte_store();
        logic [31:0] d;
        logic e;
        access(0, 1'b1, 2'b00, 1'b0, 32'h13, 32'h0000_00AA, d, e);
        access(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, d, e);
        testsRun++;
        if (d !== 32'hAAAD_BEEF) begin
            testsFailed++;
            $display("FAIL byte_store: got %h, expected aaadbeef", d);
        end
    endtask

    task automatic test_errors();
        logic [31:0] d;
        logic e;
        logic        weT  [7];
        logic [1:0]  szT  [7];
        logic [31:0] adrT [7];
        weT  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        szT  = '{2'b10, 2'b01, 2'b11, 2'b10, 2'b10, 2'b01, 2'b00};
        adrT = '{32'h12, 32'h21, 32'h30, 32'(4 * DEPTH), 32'h12, 32'h21, 32'(4 * DEPTH + 1)};
        for (int i = 0; i < 7; i++) begin
            access(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, d, e);
            access(0, weT[i], szT[i], 1'b0, adrT[i], 32'h1234_5678, d, e);
            testsRun++;
            if (e !== 1'b1 || d !== 32'h0) begin
                testsFailed++;
                $display("FAIL error_case %0d: err %b rdata %h, expected 1 00000000", i, e, d);
            end
        end
        access(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, d, e);
        testsRun++;
        if (d !== 32'hAAAD_BEEF) begin
            testsFailed++;
            $display("FAIL error_no_write_10: got %h, expected aaadbeef", d);
        end
        access(0, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, d, e);
        testsRun++;
        if (d !== 32'h0000_80F0) begin
            testsFailed++;
            $display("FAIL error_no_write_20: got %h, expected 000080f0", d);
        end
    endtask

    task automatic test_random();
        logic [31:0] d;
        logic e;
        logic [31:0] a;
        logic [1:0] sz;
        for (int i = 0; i < 200; i++) begin
            sz = ($urandom_range(7, 0) == 0) ? 2'b11 : 2'($urandom_range(2, 0));
            a = ($urandom_range(9, 0) == 0) ? $urandom : 32'($urandom_range(4 * DEPTH - 1, 0));
            access(0, 1'($urandom_range(1, 0)), sz, 1'($urandom_range(1, 0)), a, $urandom, d, e);
        end
    endtask

    // LATENCY=0 with req held high: an access every second cycle, inputs changed between acks.
    task automatic test_back_to_back();
        logic [31:0] adrT [4];
        logic [31:0] datT [4];
        for (int i = 0; i < 4; i++) begin
            adrT[i] = 32'(8 * i + 4);
            datT[i] = $urandom;
        end
        @(negedge clk);
        we = 1'b1; size = 2'b10; uns = 1'b0; addr = adrT[0]; wdata = datT[0]; reqV[1] = 1'b1;
        for (int op = 0; op < 8; op++) begin
            @(negedge clk);
            testsRun++;
            if (ackV[1] !== 1'b1 || errV[1] !== 1'b0) begin
                testsFailed++;
                $display("FAIL b2b_ack op %0d: ack %b err %b, expected 1 0", op, ackV[1], errV[1]);
            end
            if (op >= 4) begin
                testsRun++;
                if (rdata1 !== datT[op - 4]) begin
                    testsFailed++;
                    $display("FAIL b2b_rdata op %0d: got %h, expected %h", op, rdata1, datT[op - 4]);
                end
                refRdata[1] = datT[op - 4];
            end else begin
                refMem[1][adrT[op] / 4] = datT[op];
            end
            @(negedge clk);
            testsRun++;
            if (ackV[1] !== 1'b0 || busyV[1] !== 1'b0) begin
                testsFailed++;
                $display("FAIL b2b_gap op %0d: ack %b busy %b, expected 0 0", op, ackV[1], busyV[1]);
            end
            if (op < 3) begin
                addr = adrT[op + 1]; wdata = datT[op + 1];
            end else if (op < 7) begin
                we = 1'b0; addr = adrT[op - 3]; wdata = 32'h0;
            end else begin
                reqV[1] = 1'b0;
            end
        end
        @(negedge clk);
        testsRun++;
        if (ackV[1] !== 1'b0 || busyV[1] !== 1'b0) begin
            testsFailed++;
            $display("FAIL b2b_stop: ack %b busy %b, expected 0 0", ackV[1], busyV[1]);
        end
    endtask

    // LATENCY=3: a store to 0x8 requested while busy must be dropped, not queued.
    task automatic test_busy_ignore();
        logic [31:0] d;
        logic e;
        logic [31:0] keep;
        logic [31:0] first;
        int acks;
        int ackAt;
        keep = $urandom;
        first = $urandom;
        access(2, 1'b1, 2'b10, 1'b0, 32'h8, keep, d, e);
        @(negedge clk);
        we = 1'b1; size = 2'b10; uns = 1'b0; addr = 32'h4; wdata = first; reqV[2] = 1'b1;
        @(posedge clk);
        #1 reqV[2] = 1'b0;
        acks = 0; ackAt = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (ackV[2]) begin
                acks++;
                ackAt = k;
            end
            if (k == 1) begin
                addr = 32'h8; wdata = ~keep; reqV[2] = 1'b1;
            end
            if (k == 5) reqV[2] = 1'b0;
        end
        testsRun++;
        if (acks != 1 || ackAt != 4) begin
            testsFailed++;
            $display("FAIL busy_ignore_acks: %0d acks last at %0d, expected 1 at 4", acks, ackAt);
        end
        refMem[2][1] = first;
        access(2, 1'b0, 2'b10, 1'b0, 32'h8, 32'h0, d, e);
        testsRun++;
        if (d !== keep) begin
            testsFailed++;
            $display("FAIL busy_ignore_data: got %h, expected %h", d, keep);
        end
        access(2, 1'b0, 2'b10, 1'b0, 32'h4, 32'h0, d, e);
    endtask

    // Reset during WAIT (d=1) and on the edge that would enter RESP (d=2).
    task automatic test_reset_in_wait();
        logic [31:0] d;
        logic e;
        logic [31:0] old;
        int acks;
        for (int dly = 1; dly <= 2; dly++) begin
            old = refMem[0][16];
            @(negedge clk);
            we = 1'b1; size = 2'b10; uns = 1'b0; addr = 32'h40; wdata = ~old; reqV[0] = 1'b1;
            @(posedge clk);
            #1 reqV[0] = 1'b0;
            repeat (dly) @(negedge clk);
            rst = 1'b0;
            @(negedge clk);
            testsRun++;
            if (busyV[0] !== 1'b0 || ackV[0] !== 1'b0 || rdata0 !== 32'h0) begin
                testsFailed++;
                $display("FAIL reset_in_wait d%0d: busy %b ack %b rdata %h, expected 0 0 00000000", dly, busyV[0], ackV[0], rdata0);
            end
            rst = 1'b1;
            for (int s = 0; s < 3; s++) refRdata[s] = 32'h0;
            acks = 0;
            repeat (6) begin
                @(negedge clk);
                if (ackV[0]) acks++;
            end
            testsRun++;
            if (acks != 0) begin
                testsFailed++;
                $display("FAIL reset_no_ack d%0d: %0d acks, expected 0", dly, acks);
            end
            access(0, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, d, e);
            testsRun++;
            if (d !== old) begin
                testsFailed++;
                $display("FAIL reset_no_write d%0d: got %h, expected %h", dly, d, old);
            end
        end
    endtask

    initial begin
        testsRun = 0;
        testsFailed = 0;
        rst = 1'b0;
        reqV = 3'b000;
        we = 1'b0; size = 2'b00; uns = 1'b0; addr = 32'h0; wdata = 32'h0;
        test_reset();
        test_init();
        test_basic();
        test_sign_extend();
        test_byte_store();
        test_errors();
        test_random();
        test_back_to_back();
        test_busy_ignore();
        test_reset_in_wait();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter LATENCY, default 2, number of wait cycles between request capture and response; legal range 0..15.
REQ-002 Parameter DEPTH_WORDS, default 64, number of 32-bit words in the internal data array.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low; sampled on rising clk edge.
REQ-005 req  input  1  request strobe from the control FSM; sampled only in IDLE.
REQ-006 we  input  1  1 = store, 0 = load.
REQ-007 size  input  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-008 uns  input  1  1 = zero-extend load result, 0 = sign-extend.
REQ-009 addr  input  32  byte address.
REQ-010 wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-011 busy  output  1  high whenever state is not IDLE.
REQ-012 ack  output  1  one-cycle completion pulse.
REQ-013 rdata  output  32  registered load result; held between acks.
REQ-014 err  output  1  pulsed together with ack when the request was rejected.

Function
REQ-015 FSM states: IDLE, WAIT, RESP; encoding is free.
REQ-016 IDLE, req=1 at edge T: capture addr, we, size, uns, wdata; load wait counter with LATENCY; go WAIT (LATENCY>0) or RESP (LATENCY=0).
REQ-017 WAIT: decrement counter each cycle; go RESP at the edge where the counter reaches 1, so ack is high exactly in cycle T+LATENCY+1.
REQ-018 RESP: ack=1 for exactly one cycle; next state IDLE unconditionally.
REQ-019 req while busy=1 (WAIT or RESP) is ignored, not queued; next acceptance earliest in the IDLE cycle after RESP (throughput one request per LATENCY+2 cycles).
REQ-020 Memory write and rdata update occur at the edge entering RESP; a request accepted after ack observes the written data.
REQ-021 Word index = addr[31:2]; lane select = addr[1:0]; little-endian lane mapping (lane 0 = bits [7:0]).
REQ-022 Store byte: writes wdata[7:0] into the selected lane only; store half: writes wdata[15:0] into lanes addr[1]*2..+1; store word: full word; unselected lanes unchanged.
REQ-023 Load byte/half: selected lane(s) right-aligned, upper bits filled with bit 7/15 when uns=0, zeros when uns=1; load word ignores uns.
REQ-024 Store acks leave rdata at its previous value.
REQ-025 Error when any of: size=11; size=01 and addr[0]=1; size=10 and addr[1:0]!=0; addr[31:2] >= DEPTH_WORDS.
REQ-026 On error: same latency, ack=1 and err=1 in the RESP cycle, no memory write, rdata forced to 0.
REQ-027 err=0 in every cycle where ack=0.

Reset
REQ-028 rst=0 at an edge: state IDLE, counter 0, busy 0, ack 0, err 0, rdata 0; memory array contents not cleared.
REQ-029 Reset has priority over all transitions; rst=0 on the edge that would enter RESP suppresses the write and the ack.
REQ-030 req sampled during the reset edge is discarded.

Verification
REQ-031 LATENCY=2, sw addr 0x10 wdata 0xDEADBEEF, then lw addr 0x10 -> each ack exactly 3 cycles after req edge, busy high 3 cycles, rdata=0xDEADBEEF, err=0.
REQ-032 Word at 0x20 = 0x000080F0; lb addr 0x20 uns=0 -> 0xFFFFFFF0; lbu -> 0x000000F0; lh addr 0x20 uns=0 -> 0xFFFF80F0; lhu addr 0x22 -> 0x00000000.
REQ-033 sb addr 0x13 wdata 0x000000AA onto 0xDEADBEEF at 0x10 -> lw 0x10 returns 0xAAADBEEF.
REQ-034 lw addr 0x12, lh addr 0x21, size=11, lw addr 4*DEPTH_WORDS -> each ack with err=1, rdata=0, target memory unchanged.
REQ-035 req held high continuously, LATENCY=0 -> ack every second cycle, one access per ack; second req during WAIT with LATENCY=3 ignored (single ack).
REQ-036 rst=0 asserted in WAIT of a sw -> busy/ack 0 next cycle, no ack ever issued, subsequent lw shows old data.
